fir_mac: RTL and testbench

FIR_MAC -- requirements
Module: fir_mac

---
 rtl/fir_mac.sv | 128 ++++++++++++
 tb/tb_fir_mac.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac.sv
// Sequential FIR filter: one multiply-accumulate per clock, coefficients fetched from an external registered ROM.
// Define FIR_SATURATE_EN to clamp the result to OutSize; otherwise the result wraps to its low OutSize bits.
module fir_mac #(
  parameter int NrOfTaps  = 5,
  parameter int WordSize  = 12,
  parameter int AddrsSize = 3,
  parameter int AccSize   = 2*WordSize+3,
  parameter int OutSize   = 16,
  parameter int Shift     = 0
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic [WordSize-1:0]  sampleIn,
  input  logic                 sampleValid,
  output logic                 ready,
  output logic                 romRead,
  output logic [AddrsSize-1:0] romAddrs,
  input  logic [WordSize-1:0]  romData,
  output logic [OutSize-1:0]   dataOut,
  output logic                 dataValid
);

  // state | meaning
  // IDLE  | waiting for a sample, ready high
  // RUN   | reading coefficient k, accumulating the product fetched last cycle
  // DRAIN | adding the final product and publishing the result
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t state_q, state_d;

  logic signed [WordSize-1:0]   taps [NrOfTaps];
  logic signed [AccSize-1:0]    acc;
  logic [AddrsSize-1:0]         k;
  logic [AddrsSize-1:0]         k_pipe;
  logic                         prod_vld;
  logic                         accept;
  logic                         last_tap;
  logic signed [2*WordSize-1:0] prod;
  logic signed [AccSize-1:0]    sum;
  logic [OutSize-1:0]           formatted;

  assign accept   = (state_q == IDLE) && sampleValid;
  assign last_tap = (k == AddrsSize'(NrOfTaps-1));

  // romData arrives one cycle after its read, so it pairs with the tap index of the previous cycle
  assign prod = (2*WordSize)'($signed(romData)) * (2*WordSize)'(taps[k_pipe]);
  assign sum  = acc + AccSize'(prod);

`ifdef FIR_SATURATE_EN
  localparam logic signed [AccSize-1:0] SatMax = {{(AccSize-OutSize+1){1'b0}}, {(OutSize-1){1'b1}}};
  localparam logic signed [AccSize-1:0] SatMin = ~SatMax;

  logic signed [AccSize-1:0] shifted;

  always_comb begin
    shifted = sum >>> Shift;
    if (shifted > SatMax)
      formatted = {1'b0, {(OutSize-1){1'b1}}};
    else if (shifted < SatMin)
      formatted = {1'b1, {(OutSize-1){1'b0}}};
    else
      formatted = shifted[OutSize-1:0];
  end
`else
  assign formatted = OutSize'(sum >>> Shift);
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    ready    = 1'b0;
    romRead  = 1'b0;
    romAddrs = '0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (sampleValid)
          state_d = RUN;
      end
      RUN: begin
        romRead  = 1'b1;
        romAddrs = k;
        if (last_tap)
          state_d = DRAIN;
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      taps      <= '{default: '0};
      acc       <= '0;
      k         <= '0;
      k_pipe    <= '0;
      prod_vld  <= 1'b0;
      dataOut   <= '0;
      dataValid <= 1'b0;
    end else begin
      dataValid <= 1'b0;
      prod_vld  <= (state_q == RUN);
      k_pipe    <= k;
      if (accept) begin
        taps[0] <= sampleIn;
        for (int i = 1; i < NrOfTaps; i++)
          taps[i] <= taps[i-1];
        acc <= '0;
        k   <= '0;
      end
      if (state_q == RUN)
        k <= k + AddrsSize'(1);
      if (prod_vld)
        acc <= sum;
      if (state_q == DRAIN) begin
        dataOut   <= formatted;
        dataValid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fir_mac.sv
// Bench for fir_mac: registered coefficient ROM, cycle-level reference model, directed and random stimulus.
// Build with +define+FIR_SATURATE_EN to check the clamping variant.
`timescale 1ns/1ps
module tb_fir_mac;
  localparam int NrOfTaps  = 5;
  localparam int WordSize  = 12;
  localparam int AddrsSize = 3;
  localparam int AccSize   = 2*WordSize+3;
  localparam int OutSize   = 16;
  localparam int Shift     = 0;

  localparam logic [WordSize-1:0] DefCoeff [NrOfTaps] = '{12'h8, 12'hfe7, 12'hfac, 12'heb, 12'h37a};

`ifdef FIR_SATURATE_EN
  localparam longint SatHi  = (longint'(1) <<< (OutSize-1)) - 1;
  localparam longint SatLo  = -(longint'(1) <<< (OutSize-1));
  localparam longint OvfPos = 32767;
  localparam longint OvfNeg = -32768;
`else
  localparam longint OvfPos = -1024;
  localparam longint OvfNeg = 0;
`endif

  logic                 clk = 1'b0;
  logic                 resetN = 1'b1;
  logic [WordSize-1:0]  sampleIn = '0;
  logic                 sampleValid = 1'b0;
  logic                 ready;
  logic                 romRead;
  logic [AddrsSize-1:0] romAddrs;
  logic [WordSize-1:0]  romData = '0;
  logic [OutSize-1:0]   dataOut;
  logic                 dataValid;

  fir_mac #(
    .NrOfTaps(NrOfTaps), .WordSize(WordSize), .AddrsSize(AddrsSize),
    .AccSize(AccSize), .OutSize(OutSize), .Shift(Shift)
  ) dut (
    .clk(clk), .resetN(resetN), .sampleIn(sampleIn), .sampleValid(sampleValid),
    .ready(ready), .romRead(romRead), .romAddrs(romAddrs), .romData(romData),
    .dataOut(dataOut), .dataValid(dataValid)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  logic [WordSize-1:0] coeff [NrOfTaps];

  always @(posedge clk)
    if (romRead === 1'b1)
      romData <= coeff[romAddrs];

  // Reference: history of accepted samples, newest first; phase counts cycles since acceptance.
  int     hist[$];
  longint exp_q[$];
  int     phase = 0;
  bit     dv_exp = 1'b0;
  longint last_out = 0;
  int     n_acc = 0;
  int     n_done = 0;
  int     n_pulses = 0;

  function automatic longint ref_out();
    longint s = 0;
    for (int i = 0; i < hist.size() && i < NrOfTaps; i++)
      s += longint'($signed(coeff[i])) * longint'(hist[i]);
    s = s >>> Shift;
`ifdef FIR_SATURATE_EN
    if (s > SatHi) s = SatHi;
    else if (s < SatLo) s = SatLo;
    return s;
`else
    return longint'($signed(s[OutSize-1:0]));
`endif
  endfunction

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      phase    = 0;
      dv_exp   = 1'b0;
      last_out = 0;
      hist.delete();
      exp_q.delete();
    end else begin
      dv_exp = (phase == NrOfTaps + 1);
      if (dv_exp) begin
        n_done++;
        if (exp_q.size() > 0) last_out = exp_q.pop_front();
        phase = 0;
      end else if (phase != 0) begin
        phase++;
      end else if (sampleValid) begin
        hist.push_front(int'($signed(sampleIn)));
        if (hist.size() > NrOfTaps) void'(hist.pop_back());
        exp_q.push_back(ref_out());
        n_acc++;
        phase = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (resetN) begin
      chk("ready", ready, phase == 0);
      chk("romRead", romRead, phase >= 1 && phase <= NrOfTaps);
      chk("romAddrs", romAddrs, (phase >= 1 && phase <= NrOfTaps) ? phase - 1 : 0);
      chk("dataValid", dataValid, dv_exp);
      chk("dataOut", $signed(dataOut), last_out);
      if (dataValid === 1'b1) n_pulses++;
    end
  end

  // Offers one sample, returns the result and the number of edges from acceptance to the pulse.
  task automatic send(input int s, output logic [OutSize-1:0] y, output int lat);
    int cyc = 0;
    @(negedge clk);
    sampleIn    = s[WordSize-1:0];
    sampleValid = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
    end while (phase != 1 && cyc < 40);
    sampleValid = 1'b0;
    lat = 0;
    while (dataValid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    y = dataOut;
  endtask

  task automatic impulse(input string tag);
    int lits [6] = '{8, -25, -84, 235, 890, 0};
    int lat;
    logic [OutSize-1:0] y;
    for (int i = 0; i < 6; i++) begin
      send((i == 0) ? 1 : 0, y, lat);
      chk({tag, "_out"}, $signed(y), lits[i]);
      chk({tag, "_latency"}, lat, NrOfTaps + 1);
    end
  endtask

  // sampleValid held high; the sample changes only once it has been taken.
  task automatic stream(input int count, input bit alt);
    int got = 0;
    int cyc = 0;
    @(negedge clk);
    sampleIn    = alt ? WordSize'(100) : WordSize'($urandom);
    sampleValid = 1'b1;
    while (got < count && cyc < count * (NrOfTaps + 2) + 20) begin
      @(negedge clk);
      cyc++;
      if (phase == 1) begin
        got++;
        sampleIn = alt ? ((got % 2 == 1) ? WordSize'(-100) : WordSize'(100)) : WordSize'($urandom);
      end
    end
    sampleValid = 1'b0;
    repeat (NrOfTaps + 4) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, ready, 1);
    chk({tag, "_romRead"}, romRead, 0);
    chk({tag, "_romAddrs"}, romAddrs, 0);
    chk({tag, "_dataValid"}, dataValid, 0);
    chk({tag, "_dataOut"}, dataOut, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, observed no end, expected $finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int cyc;
    int p0;
    logic [OutSize-1:0] y;

    coeff = DefCoeff;
    #2 resetN = 1'b0;
    #1 check_reset_outputs("rst");
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", ready, 1);

    impulse("imp");

    for (int i = 0; i < NrOfTaps; i++) send(2047, y, lat);
    chk("ovf_pos", $signed(y), OvfPos);
    for (int i = 0; i < NrOfTaps; i++) send(-2048, y, lat);
    chk("ovf_neg", $signed(y), OvfNeg);

    stream(20, 1'b0);
    chk("held_valid_count", n_pulses, n_done);
    stream(20, 1'b1);
    chk("b2b_valid_count", n_pulses, n_done);

    for (int i = 0; i < NrOfTaps; i++) coeff[i] = WordSize'($urandom);
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      case ($urandom_range(0, 3))
        0:       send(2047, y, lat);
        1:       send(-2048, y, lat);
        default: send(int'($signed(WordSize'($urandom))), y, lat);
      endcase
      chk("rand_latency", lat, NrOfTaps + 1);
    end
    stream(10, 1'b0);
    chk("rand_valid_count", n_pulses, n_done);

    coeff = DefCoeff;
    @(negedge clk);
    sampleIn    = WordSize'(1);
    sampleValid = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (phase != 1 && cyc < 40);
    sampleValid = 1'b0;
    while (phase != 3 && cyc < 80) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort_point", romAddrs, 2);
    p0 = n_pulses;
    resetN = 1'b0;
    #1 check_reset_outputs("abort_rst");
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    chk("ready_after_abort", ready, 1);
    repeat (NrOfTaps + 5) @(negedge clk);
    chk("abort_no_valid", n_pulses - p0, 0);

    impulse("imp_after_abort");

    repeat (10) @(negedge clk);
    chk("final_valid_count", n_pulses, n_done);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
